// File: rtl/cplx_matmul_pkg.sv
// Shared types and sizing helpers for the sequential complex matrix multiplier.
package cplx_matmul_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    EMIT
  } state_t;

  // Full-precision width: one W*W product is 2*W bits, the complex
  // combination of two products adds one bit, and N terms add clog2(N).
  function automatic int acc_width(input int n, input int w);
    return 2 * w + 1 + $clog2(n);
  endfunction

  function automatic int elem_lsb(input int r, input int c, input int n, input int w);
    return (r * n + c) * w;
  endfunction

endpackage

// File: rtl/cplx_matmul_seq_mac.sv
// Single complex multiply-accumulate. The sum is exposed combinationally so the
// owner can capture the final total on the same edge that clears the accumulator.
module cplx_mac
  import cplx_matmul_pkg::*;
#(
  parameter int W     = 16,
  parameter int ACC_W = acc_width(4, W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic             conj,
  input  logic [W-1:0]     a_re,
  input  logic [W-1:0]     a_im,
  input  logic [W-1:0]     b_re,
  input  logic [W-1:0]     b_im,
  output logic [ACC_W-1:0] sum_re,
  output logic [ACC_W-1:0] sum_im
);

  logic signed [2*W-1:0] p_rr;
  logic signed [2*W-1:0] p_ii;
  logic signed [2*W-1:0] p_ri;
  logic signed [2*W-1:0] p_ir;
  logic [ACC_W-1:0]      e_rr;
  logic [ACC_W-1:0]      e_ii;
  logic [ACC_W-1:0]      e_ri;
  logic [ACC_W-1:0]      e_ir;
  logic [ACC_W-1:0]      acc_re;
  logic [ACC_W-1:0]      acc_im;

  assign p_rr = $signed(a_re) * $signed(b_re);
  assign p_ii = $signed(a_im) * $signed(b_im);
  assign p_ri = $signed(a_re) * $signed(b_im);
  assign p_ir = $signed(a_im) * $signed(b_re);

  assign e_rr = {{(ACC_W-2*W){p_rr[2*W-1]}}, p_rr};
  assign e_ii = {{(ACC_W-2*W){p_ii[2*W-1]}}, p_ii};
  assign e_ri = {{(ACC_W-2*W){p_ri[2*W-1]}}, p_ri};
  assign e_ir = {{(ACC_W-2*W){p_ir[2*W-1]}}, p_ir};

  // Conjugating B flips the sign of every b_im term.
  assign sum_re = conj ? (acc_re + e_rr + e_ii) : (acc_re + e_rr - e_ii);
  assign sum_im = conj ? (acc_im + e_ir - e_ri) : (acc_im + e_ir + e_ri);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_re <= '0;
      acc_im <= '0;
    end else if (clear) begin
      acc_re <= '0;
      acc_im <= '0;
    end else if (en) begin
      acc_re <= sum_re;
      acc_im <= sum_im;
    end
  end

endmodule

// File: rtl/cplx_matmul_seq.sv
// Sequential N x N complex matrix multiplier C = A * op(B): one shared complex MAC,
// row-major result streaming over valid/ready, with busy/done status.
module cplx_matmul_seq
  import cplx_matmul_pkg::*;
#(
  parameter int N     = 4,
  parameter int W     = 16,
  parameter int ACC_W = acc_width(N, W)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 conj_b,
  input  logic [N*N*W-1:0]     a_re,
  input  logic [N*N*W-1:0]     a_im,
  input  logic [N*N*W-1:0]     b_re,
  input  logic [N*N*W-1:0]     b_im,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_W-1:0]     out_re,
  output logic [ACC_W-1:0]     out_im,
  output logic [$clog2(N)-1:0] out_row,
  output logic [$clog2(N)-1:0] out_col,
  output logic                 busy,
  output logic                 done
);

  localparam int            IW    = $clog2(N);
  localparam int            LSB_W = $clog2(N * N * W);
  localparam logic [IW-1:0] LAST  = IW'(N - 1);

  state_t           state;
  logic [IW-1:0]    i;
  logic [IW-1:0]    j;
  logic [IW-1:0]    k;
  logic             conj_q;
  logic [N*N*W-1:0] a_re_q;
  logic [N*N*W-1:0] a_im_q;
  logic [N*N*W-1:0] b_re_q;
  logic [N*N*W-1:0] b_im_q;

  logic [LSB_W-1:0] a_lsb;
  logic [LSB_W-1:0] b_lsb;
  logic [W-1:0]     a_sel_re;
  logic [W-1:0]     a_sel_im;
  logic [W-1:0]     b_sel_re;
  logic [W-1:0]     b_sel_im;
  logic [ACC_W-1:0] sum_re;
  logic [ACC_W-1:0] sum_im;
  logic             mac_clear;
  logic             mac_en;

  // A is walked along row i, B down column j, both indexed by k.
  assign a_lsb    = LSB_W'(elem_lsb(int'(i), int'(k), N, W));
  assign b_lsb    = LSB_W'(elem_lsb(int'(k), int'(j), N, W));
  assign a_sel_re = a_re_q[a_lsb +: W];
  assign a_sel_im = a_im_q[a_lsb +: W];
  assign b_sel_re = b_re_q[b_lsb +: W];
  assign b_sel_im = b_im_q[b_lsb +: W];

  assign mac_en    = (state == MAC);
  assign mac_clear = ((state == IDLE) && start) || ((state == MAC) && (k == LAST));

  cplx_mac #(
    .W     (W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk    (clk),
    .rst    (rst),
    .clear  (mac_clear),
    .en     (mac_en),
    .conj   (conj_q),
    .a_re   (a_sel_re),
    .a_im   (a_sel_im),
    .b_re   (b_sel_re),
    .b_im   (b_sel_im),
    .sum_re (sum_re),
    .sum_im (sum_im)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      i         <= '0;
      j         <= '0;
      k         <= '0;
      conj_q    <= 1'b0;
      a_re_q    <= '0;
      a_im_q    <= '0;
      b_re_q    <= '0;
      b_im_q    <= '0;
      out_valid <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      out_row   <= '0;
      out_col   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_re_q <= a_re;
            a_im_q <= a_im;
            b_re_q <= b_re;
            b_im_q <= b_im;
            conj_q <= conj_b;
            i      <= '0;
            j      <= '0;
            k      <= '0;
            busy   <= 1'b1;
            state  <= MAC;
          end
        end
        MAC: begin
          if (k == LAST) begin
            out_re    <= sum_re;
            out_im    <= sum_im;
            out_row   <= i;
            out_col   <= j;
            out_valid <= 1'b1;
            k         <= '0;
            state     <= EMIT;
          end else begin
            k <= k + 1'b1;
          end
        end
        EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if ((i == LAST) && (j == LAST)) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              if (j == LAST) begin
                j <= '0;
                i <= i + 1'b1;
              end else begin
                j <= j + 1'b1;
              end
              state <= MAC;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cplx_matmul_seq.sv
// Directed self-checking bench for cplx_matmul_seq (N=4, W=16) with hand-derived results.
module tb_cplx_matmul_seq;

  localparam int N     = 4;
  localparam int W     = 16;
  localparam int IW    = 2;
  localparam int ACC_W = 2 * W + 1 + 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             conj_b;
  logic             out_ready;
  logic [N*N*W-1:0] a_re;
  logic [N*N*W-1:0] a_im;
  logic [N*N*W-1:0] b_re;
  logic [N*N*W-1:0] b_im;
  logic             out_valid;
  logic [ACC_W-1:0] out_re;
  logic [ACC_W-1:0] out_im;
  logic [IW-1:0]    out_row;
  logic [IW-1:0]    out_col;
  logic             busy;
  logic             done;

  logic [ACC_W-1:0] exp_re [N*N];
  logic [ACC_W-1:0] exp_im [N*N];

  int checks = 0;
  int errors = 0;

  cplx_matmul_seq #(
    .N     (N),
    .W     (W),
    .ACC_W (ACC_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .conj_b    (conj_b),
    .a_re      (a_re),
    .a_im      (a_im),
    .b_re      (b_re),
    .b_im      (b_im),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_row   (out_row),
    .out_col   (out_col),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_valid"}, 64'(out_valid), 64'd0);
    check_output({tag, "_busy"},  64'(busy),      64'd0);
    check_output({tag, "_done"},  64'(done),      64'd0);
    check_output({tag, "_re"},    64'(out_re),    64'd0);
    check_output({tag, "_im"},    64'(out_im),    64'd0);
    check_output({tag, "_row"},   64'(out_row),   64'd0);
    check_output({tag, "_col"},   64'(out_col),   64'd0);
  endtask

  task automatic clear_operands();
    a_re = '0;
    a_im = '0;
    b_re = '0;
    b_im = '0;
    for (int e = 0; e < N * N; e++) begin
      exp_re[e] = '0;
      exp_im[e] = '0;
    end
  endtask

  // A = I, B(r,c) = (r*4+c) - j(r*4+c); result equals B.
  task automatic load_identity();
    clear_operands();
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        if (r == c) a_re[(r*N+c)*W +: W] = 16'd1;
        b_re[(r*N+c)*W +: W] = 16'(r * 4 + c);
        b_im[(r*N+c)*W +: W] = 16'(-(r * 4 + c));
        exp_re[r*N+c] = ACC_W'(r * 4 + c);
        exp_im[r*N+c] = ACC_W'(-(r * 4 + c));
      end
    end
  endtask

  // A = B = jI: j*j = -1, j*conj(j) = +1 on the diagonal.
  task automatic load_imag_unit(input logic cj);
    clear_operands();
    for (int r = 0; r < N; r++) begin
      a_im[(r*N+r)*W +: W] = 16'd1;
      b_im[(r*N+r)*W +: W] = 16'd1;
      exp_re[r*N+r] = cj ? ACC_W'(1) : ACC_W'(-1);
    end
  endtask

  // Every part -32768: each product 2^30, four terms per element.
  task automatic load_extremes(input logic cj);
    for (int e = 0; e < N * N; e++) begin
      a_re[e*W +: W] = 16'h8000;
      a_im[e*W +: W] = 16'h8000;
      b_re[e*W +: W] = 16'h8000;
      b_im[e*W +: W] = 16'h8000;
      exp_re[e] = cj ? ACC_W'(64'sd8589934592) : ACC_W'(0);
      exp_im[e] = cj ? ACC_W'(0) : ACC_W'(64'sd8589934592);
    end
  endtask

  task automatic check_element(input int idx);
    if (idx < N * N) begin
      check_output($sformatf("elem%0d_re", idx),  64'(out_re),  64'(exp_re[idx]));
      check_output($sformatf("elem%0d_im", idx),  64'(out_im),  64'(exp_im[idx]));
      check_output($sformatf("elem%0d_row", idx), 64'(out_row), 64'(idx / N));
      check_output($sformatf("elem%0d_col", idx), 64'(out_col), 64'(idx % N));
    end else begin
      check_output("extra_element", 64'(idx), 64'(N * N - 1));
    end
  endtask

  // Runs one job from a negedge in IDLE and checks the stream, latency and status.
  task automatic apply_stimulus(input string tag, input logic cj, input int stall_idx,
                                input int stall_len, input int inject_at, input int exp_total);
    int edges;
    int idx;
    int first_valid;
    int done_cnt;
    conj_b    = cj;
    out_ready = 1'b1;
    start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check_output({tag, "_busy_start"}, 64'(busy), 64'd1);
    edges       = 0;
    idx         = 0;
    first_valid = -1;
    done_cnt    = 0;
    while (edges < 600 && done_cnt == 0) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      start = 1'b0;
      if (edges == inject_at) begin
        start  = 1'b1;
        conj_b = ~cj;
        a_re   = '1;
        a_im   = '1;
        b_re   = '1;
        b_im   = '1;
      end
      if (out_valid) begin
        if (first_valid < 0) first_valid = edges;
        check_output({tag, "_busy_run"}, 64'(busy), 64'd1);
        if (idx == stall_idx) begin
          out_ready = 1'b0;
          repeat (stall_len) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            check_output({tag, "_stall_valid"}, 64'(out_valid), 64'd1);
            check_element(idx);
          end
          out_ready = 1'b1;
        end
        check_element(idx);
        idx++;
      end
      if (done) done_cnt++;
    end
    check_output({tag, "_done_seen"},   64'(done_cnt),    64'd1);
    check_output({tag, "_first_valid"}, 64'(first_valid), 64'(N));
    check_output({tag, "_total"},       64'(edges),       64'(exp_total));
    check_output({tag, "_count"},       64'(idx),         64'(N * N));
    check_output({tag, "_busy_done"},   64'(busy),        64'd0);
    @(posedge clk);
    @(negedge clk);
    check_output({tag, "_done_pulse"}, 64'(done), 64'd0);
    repeat (5) @(negedge clk);
    check_output({tag, "_idle_valid"}, 64'(out_valid), 64'd0);
    check_output({tag, "_idle_busy"},  64'(busy),      64'd0);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    conj_b    = 1'b0;
    out_ready = 1'b1;
    clear_operands();
    #1;
    check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] identity");
    load_identity();
    apply_stimulus("ident", 1'b0, -1, 0, -1, N * N * (N + 1));

    $display("[TB] imaginary unit");
    load_imag_unit(1'b0);
    apply_stimulus("jj", 1'b0, -1, 0, -1, 80);
    load_imag_unit(1'b1);
    apply_stimulus("jj_conj", 1'b1, -1, 0, -1, 80);

    $display("[TB] extremes");
    load_extremes(1'b0);
    apply_stimulus("ext", 1'b0, -1, 0, -1, 80);
    load_extremes(1'b1);
    apply_stimulus("ext_conj", 1'b1, -1, 0, -1, 80);

    $display("[TB] backpressure on (1,2)");
    load_identity();
    apply_stimulus("stall", 1'b0, 1 * N + 2, 7, -1, 87);

    $display("[TB] start while busy");
    load_identity();
    apply_stimulus("busy_start", 1'b0, -1, 0, 20, 80);

    $display("[TB] reset mid-job");
    load_identity();
    conj_b    = 1'b0;
    out_ready = 1'b1;
    start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (47) @(posedge clk);
    @(negedge clk);
    check_output("pre_rst_busy", 64'(busy),    64'd1);
    check_output("pre_rst_row",  64'(out_row), 64'd2);
    check_output("pre_rst_re",   64'(out_re),  64'd8);
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check_output("post_rst_valid", 64'(out_valid), 64'd0);
    end
    load_identity();
    apply_stimulus("after_rst", 1'b0, -1, 0, -1, 80);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
